dual_lane_accum_requant: RTL and testbench

Downstream consumer of the packed dual-lane 24×8 multiplier stage. Each cycle it takes two sign-extended 20-bit partial products, lane A and lane B, which are two output pixels computed against one shared weight. It accumulates them over a convolution window, adds a per-lane bias, applies a rounding arithmetic right shift and saturates to int8. Window boundaries are marked on the tap issued to the multiplier, and the block delays those markers internally to line up with the multiplier's pipeline.

---
 rtl/dual_lane_accum_requant.sv | 162 ++++++++++++++++
 tb/tb_dual_lane_accum_requant.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_lane_accum_requant.sv
// Dual-lane window accumulator with per-lane bias, rounding right shift and int8 saturation.
// Tap markers are delayed internally so they line up with the multiplier's product pipeline.
module dual_lane_accum_requant #(
    parameter int unsigned PROD_W   = 20,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned MULT_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tap_valid,
    input  logic                     tap_first,
    input  logic                     tap_last,
    input  logic signed [PROD_W-1:0] prod_a,
    input  logic signed [PROD_W-1:0] prod_b,
    input  logic signed [ACC_W-1:0]  bias_a,
    input  logic signed [ACC_W-1:0]  bias_b,
    input  logic        [4:0]        shift,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_a,
    output logic signed [OUT_W-1:0]  out_b,
    output logic                     err
);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    localparam logic signed [ACC_W:0] SatHi = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SatLo = ~SatHi;

    logic [MULT_LAT-1:0] dl_valid, dl_first, dl_last;
    logic                d_valid, d_first, d_last;

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic signed [ACC_W-1:0] sum_a_q, sum_a_d, sum_b_q, sum_b_d;
    logic        [4:0]       shift_q, shift_d, sum_shift_q, sum_shift_d;
    logic                    fire_q, fire_d;
    logic                    err_q, err_d;
    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_a_q, out_b_q;

    logic signed [ACC_W-1:0] new_a, new_b;
    logic signed [ACC_W:0]   rnd, ext_a, ext_b, r_a, r_b;

    // Marker delay line; depth matches the multiplier latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
            dl_first <= '0;
            dl_last  <= '0;
        end else begin
            dl_valid[0] <= tap_valid;
            dl_first[0] <= tap_first;
            dl_last[0]  <= tap_last;
            for (int i = 1; i < int'(MULT_LAT); i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_first[i] <= dl_first[i-1];
                dl_last[i]  <= dl_last[i-1];
            end
        end
    end

    assign d_valid = dl_valid[MULT_LAT-1];
    assign d_first = dl_first[MULT_LAT-1];
    assign d_last  = dl_last[MULT_LAT-1];

    // A first tap always restarts from bias, even mid-window.
    assign new_a = (d_first ? bias_a : acc_a_q) + ACC_W'(prod_a);
    assign new_b = (d_first ? bias_b : acc_b_q) + ACC_W'(prod_b);

    always_comb begin
        state_d     = state_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        shift_d     = shift_q;
        sum_a_d     = sum_a_q;
        sum_b_d     = sum_b_q;
        sum_shift_d = sum_shift_q;
        fire_d      = 1'b0;
        err_d       = err_q;
        if (d_valid) begin
            if (d_first || state_q == StAccum) begin
                if (d_first && state_q == StAccum) err_d = 1'b1;
                acc_a_d = new_a;
                acc_b_d = new_b;
                if (d_first) shift_d = shift;
                if (d_last) begin
                    fire_d      = 1'b1;
                    sum_a_d     = new_a;
                    sum_b_d     = new_b;
                    // Carry the window's shift with its sum so the next window may latch its own.
                    sum_shift_d = d_first ? shift : shift_q;
                    state_d     = StIdle;
                end else begin
                    state_d = StAccum;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            shift_q     <= '0;
            sum_a_q     <= '0;
            sum_b_q     <= '0;
            sum_shift_q <= '0;
            fire_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            shift_q     <= shift_d;
            sum_a_q     <= sum_a_d;
            sum_b_q     <= sum_b_d;
            sum_shift_q <= sum_shift_d;
            fire_q      <= fire_d;
            err_q       <= err_d;
        end
    end

    // One extra bit keeps the rounding add from overflowing at large sums.
    always_comb begin
        rnd = '0;
        if (sum_shift_q != 5'd0) rnd = (ACC_W + 1)'(1) << (sum_shift_q - 5'd1);
        ext_a = {sum_a_q[ACC_W-1], sum_a_q} + rnd;
        ext_b = {sum_b_q[ACC_W-1], sum_b_q} + rnd;
        r_a   = ext_a >>> sum_shift_q;
        r_b   = ext_b >>> sum_shift_q;
    end

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W:0] v);
        if (v > SatHi) return OUT_W'(SatHi);
        if (v < SatLo) return OUT_W'(SatLo);
        return OUT_W'(v);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            out_valid_q <= fire_q;
            if (fire_q) begin
                out_a_q <= sat(r_a);
                out_b_q <= sat(r_b);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dual_lane_accum_requant.sv
// Directed bench: table of uniform windows plus hand sequences for back-to-back, gaps,
// protocol errors and reset mid-window. Products/bias/shift are delayed here to mimic the multiplier.
module tb_dual_lane_accum_requant;

    localparam int LAT = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               tap_valid, tap_first, tap_last;
    logic signed [19:0] prod_a, prod_b;
    logic signed [31:0] bias_a, bias_b;
    logic        [4:0]  shift;
    logic               out_valid;
    logic signed [7:0]  out_a, out_b;
    logic               err;

    logic signed [19:0] t_pa, t_pb;
    logic signed [31:0] t_ba, t_bb;
    logic        [4:0]  t_sh;
    logic signed [19:0] pa_pipe [LAT];
    logic signed [19:0] pb_pipe [LAT];
    logic signed [31:0] ba_pipe [LAT];
    logic signed [31:0] bb_pipe [LAT];
    logic        [4:0]  sh_pipe [LAT];

    int cyc = 0;
    int last_cyc;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int a;
        int b;
        int c;
    } res_t;
    res_t q[$];

    typedef struct {
        string name;
        int    n;
        int    pa, pb, ba, bb, sh;
        int    ea, eb;
    } vec_t;
    vec_t vecs[6];

    dual_lane_accum_requant dut (
        .clk       (clk),
        .rst       (rst),
        .tap_valid (tap_valid),
        .tap_first (tap_first),
        .tap_last  (tap_last),
        .prod_a    (prod_a),
        .prod_b    (prod_b),
        .bias_a    (bias_a),
        .bias_b    (bias_b),
        .shift     (shift),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        pa_pipe[0] <= t_pa;
        pb_pipe[0] <= t_pb;
        ba_pipe[0] <= t_ba;
        bb_pipe[0] <= t_bb;
        sh_pipe[0] <= t_sh;
        for (int i = 1; i < LAT; i++) begin
            pa_pipe[i] <= pa_pipe[i-1];
            pb_pipe[i] <= pb_pipe[i-1];
            ba_pipe[i] <= ba_pipe[i-1];
            bb_pipe[i] <= bb_pipe[i-1];
            sh_pipe[i] <= sh_pipe[i-1];
        end
    end

    assign prod_a = pa_pipe[LAT-1];
    assign prod_b = pb_pipe[LAT-1];
    assign bias_a = ba_pipe[LAT-1];
    assign bias_b = bb_pipe[LAT-1];
    assign shift  = sh_pipe[LAT-1];

    always @(negedge clk) begin
        if (out_valid) q.push_back('{int'(out_a), int'(out_b), cyc});
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input bit f, input bit l, input int pa, input int pb,
                         input int ba, input int bb, input int sh);
        @(negedge clk);
        tap_valid = 1'b1;
        tap_first = f;
        tap_last  = l;
        t_pa      = 20'(pa);
        t_pb      = 20'(pb);
        t_ba      = ba;
        t_bb      = bb;
        t_sh      = 5'(sh);
        last_cyc  = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tap_valid = 1'b0;
            tap_first = 1'b0;
            tap_last  = 1'b0;
        end
    endtask

    task automatic expect_out(input string name, input int ea, input int eb, input int ec);
        int   waited;
        res_t r;
        waited = 0;
        while (q.size() == 0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (q.size() == 0) begin
            chk({name, " timeout"}, 0, 1);
        end else begin
            r = q.pop_front();
            chk({name, " out_a"}, r.a, ea);
            chk({name, " out_b"}, r.b, eb);
            chk({name, " latency"}, r.c, ec);
        end
    endtask

    task automatic expect_none(input string name, input int n);
        repeat (n) @(negedge clk);
        #1;
        chk({name, " no extra out_valid"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        int c;
        vecs[0] = '{"basic",     9,  10,  -3,    5,     0,  2,   24,   -7};
        vecs[1] = '{"sat",       1, 300, -300,   0,     0,  0,  127, -128};
        vecs[2] = '{"bias4",     4, 100, -100, 1000, -1000, 4,   88,  -87};
        vecs[3] = '{"round1",    1,  -5,   6,    0,     0,  1,   -2,    3};
        vecs[4] = '{"shift31",   1,   0,   0, 2147483647, -2147483647 - 1, 31, 1, -1};
        vecs[5] = '{"satshift",  2, -200000, 200000, 0, 0, 8, -128,  127};

        rst = 1'b1;
        tap_valid = 1'b0; tap_first = 1'b0; tap_last = 1'b0;
        t_pa = '0; t_pb = '0; t_ba = '0; t_bb = '0; t_sh = '0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_a", int'(out_a), 0);
        chk("reset out_b", int'(out_b), 0);
        chk("reset err", int'(err), 0);
        rst = 1'b0;
        idle(2);

        foreach (vecs[v]) begin
            for (int k = 0; k < vecs[v].n; k++)
                issue(k == 0, k == vecs[v].n - 1, vecs[v].pa, vecs[v].pb,
                      vecs[v].ba, vecs[v].bb, vecs[v].sh);
            c = last_cyc;
            idle(1);
            expect_out(vecs[v].name, vecs[v].ea, vecs[v].eb, c + 4);
            expect_none(vecs[v].name, 6);
        end
        chk("held out_a", int'(out_a), -128);
        chk("err after clean windows", int'(err), 0);

        // Back-to-back: 2-tap then 1-tap; bias on the non-first tap must be ignored.
        issue(1'b1, 1'b0, 1, 0,   0, 0, 0);
        issue(1'b0, 1'b1, 2, 0, 100, 0, 0);
        issue(1'b1, 1'b1, 7, 0,   0, 0, 0);
        c = last_cyc;
        idle(1);
        expect_out("b2b first", 3, 0, c + 3);
        expect_out("b2b second", 7, 0, c + 4);
        expect_none("b2b", 6);

        // Gaps inside a window.
        issue(1'b1, 1'b0, 4, 0, 0, 0, 0);
        idle(2);
        issue(1'b0, 1'b0, 4, 0, 0, 0, 0);
        idle(2);
        issue(1'b0, 1'b1, 4, 0, 0, 0, 0);
        c = last_cyc;
        idle(1);
        expect_out("gaps", 12, 0, c + 4);
        expect_none("gaps", 6);

        // Tap without first while idle.
        issue(1'b0, 1'b1, 99, 99, 0, 0, 0);
        idle(1);
        expect_none("orphan tap", 8);
        chk("err after orphan tap", int'(err), 1);

        // First tap mid-window restarts.
        issue(1'b1, 1'b0, 10, 10, 0, 0, 0);
        issue(1'b0, 1'b0, 10, 10, 0, 0, 0);
        issue(1'b1, 1'b0,  1,  1, 0, 0, 0);
        issue(1'b0, 1'b1,  2,  2, 0, 0, 0);
        c = last_cyc;
        idle(1);
        expect_out("restart", 3, 3, c + 4);
        expect_none("restart", 6);
        chk("err sticky", int'(err), 1);

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("err cleared by rst", int'(err), 0);
        idle(2);

        // Reset after 4 of 9 taps.
        for (int k = 0; k < 4; k++) issue(k == 0, 1'b0, 10, -3, 5, 0, 2);
        @(negedge clk);
        tap_valid = 1'b0; tap_first = 1'b0; tap_last = 1'b0;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        expect_none("reset mid-window", 10);
        chk("post-reset out_a", int'(out_a), 0);
        chk("post-reset out_b", int'(out_b), 0);
        chk("post-reset out_valid", int'(out_valid), 0);
        issue(1'b1, 1'b1, 5, 0, 0, 0, 0);
        c = last_cyc;
        idle(1);
        expect_out("after reset", 5, 0, c + 4);
        expect_none("after reset", 6);
        chk("err after clean restart", int'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
